// File: rtl/alu_multicycle_if.sv
// Handshake and data bundle for alu_multicycle: an input (operation) channel
// and an output (result) channel, each with its own valid/ready pair.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [3:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             div_by_zero;

    // Producer of operations / consumer of results (e.g. pipeline control).
    modport master (
        output in_valid, left, right, control, out_ready,
        input  in_ready, out_valid, out, zero, div_by_zero
    );

    // The ALU itself.
    modport slave (
        input  in_valid, left, right, control, out_ready,
        output in_ready, out_valid, out, zero, div_by_zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU. Logic ops, add/sub and set-less-than complete in
// one edge; MUL (shift-add) and DIVU/REMU (restoring division) take WIDTH
// edges each, independent of operand values. One operation in flight at a time.
module alu_multicycle #(
    parameter int WIDTH      = 32,
    parameter bit SLT_SIGNED = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    alu_multicycle_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [3:0]       op_reg, op_next;
    // a_reg: multiplicand (shifts left) or divisor (constant).
    // b_reg: multiplier (shifts right) or dividend/quotient (shifts left).
    // acc_reg: product accumulator or partial remainder.
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             zero_reg, zero_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH-1:0] and_bits, or_bits, nor_bits;
    logic             slt_lt;
    logic [WIDTH-1:0] single_res;
    logic             is_iter;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_shift;
    logic             div_ge;
    logic [WIDTH-1:0] rem_new;
    logic [WIDTH-1:0] quo_new;
    logic [WIDTH-1:0] step_res;

    // Bitwise operations, built per bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_bits[gi] = bus.left[gi] & bus.right[gi];
            assign or_bits[gi]  = bus.left[gi] | bus.right[gi];
            assign nor_bits[gi] = ~(bus.left[gi] | bus.right[gi]);
        end
    endgenerate

    // Set-less-than compare, signedness fixed at elaboration.
    always_comb begin
        slt_lt = 1'b0;
        if (SLT_SIGNED) begin
            slt_lt = $signed(bus.left) < $signed(bus.right);
        end else begin
            slt_lt = bus.left < bus.right;
        end
    end

    // Single-cycle result from the live operands; unknown codes yield zero.
    always_comb begin
        single_res = '0;
        is_iter    = 1'b0;
        case (bus.control)
            OP_AND:  single_res = and_bits;
            OP_OR:   single_res = or_bits;
            OP_ADD:  single_res = bus.left + bus.right;
            OP_SUB:  single_res = bus.left - bus.right;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_NOR:  single_res = nor_bits;
            OP_MUL,
            OP_DIVU,
            OP_REMU: is_iter = 1'b1;
            default: single_res = '0;
        endcase
    end

    // One iteration step of shift-add multiply and restoring division.
    // With a zero divisor every trial subtract succeeds, so the quotient
    // becomes all ones and the remainder ends up equal to the dividend.
    always_comb begin
        mul_acc   = acc_reg + (b_reg[0] ? a_reg : '0);
        rem_shift = {acc_reg, b_reg[WIDTH-1]};
        div_ge    = rem_shift >= {1'b0, a_reg};
        rem_new   = div_ge ? (rem_shift[WIDTH-1:0] - a_reg) : rem_shift[WIDTH-1:0];
        quo_new   = {b_reg[WIDTH-2:0], div_ge};
        if (op_reg == OP_MUL) begin
            step_res = mul_acc;
        end else if (op_reg == OP_DIVU) begin
            step_res = quo_new;
        end else begin
            step_res = rem_new;
        end
    end

    // Next-state and datapath-update logic.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        out_next   = out_reg;
        zero_next  = zero_reg;
        dbz_next   = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    op_next = bus.control;
                    if (is_iter) begin
                        a_next     = bus.right;
                        b_next     = bus.left;
                        acc_next   = '0;
                        count_next = CW'(WIDTH);
                        state_next = RUN;
                    end else begin
                        out_next   = single_res;
                        zero_next  = (single_res == '0);
                        dbz_next   = 1'b0;
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                count_next = count_reg - 1'b1;
                if (op_reg == OP_MUL) begin
                    acc_next = mul_acc;
                    a_next   = a_reg << 1;
                    b_next   = b_reg >> 1;
                end else begin
                    acc_next = rem_new;
                    b_next   = quo_new;
                end
                if (count_reg == CW'(1)) begin
                    out_next   = step_res;
                    zero_next  = (step_res == '0);
                    dbz_next   = (op_reg != OP_MUL) && (a_reg == '0);
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            out_reg   <= '0;
            zero_reg  <= 1'b1;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
            out_reg   <= out_next;
            zero_reg  <= zero_next;
            dbz_reg   <= dbz_next;
        end
    end

    assign bus.in_ready    = (state_reg == IDLE);
    assign bus.out_valid   = (state_reg == DONE);
    assign bus.out         = out_reg;
    assign bus.zero        = zero_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: three instances (32-bit unsigned SLT, 32-bit
// signed SLT, 8-bit) share one stimulus bus; only the selected instance sees
// in_valid and only its outputs are observed.
module tb_alu_multicycle;
    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                           C_SUB = 4'b0110, C_SLT = 4'b0111, C_NOR = 4'b1100,
                           C_MUL = 4'b1000, C_DIVU = 4'b1001, C_REMU = 4'b1010;

    typedef struct {
        int          dut;
        logic [3:0]  ctl;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] exp_out;
        logic        exp_zero;
        logic        exp_dbz;
        int          exp_edges;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] left = '0;
    logic [31:0] right = '0;
    logic [3:0]  control = '0;
    int          sel = 0;

    alu_multicycle_if #(.WIDTH(32)) bus_u ();
    alu_multicycle_if #(.WIDTH(32)) bus_s ();
    alu_multicycle_if #(.WIDTH(8))  bus_w ();

    alu_multicycle #(.WIDTH(32), .SLT_SIGNED(1'b0)) dut_u (.clk(clk), .reset(reset), .bus(bus_u));
    alu_multicycle #(.WIDTH(32), .SLT_SIGNED(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));
    alu_multicycle #(.WIDTH(8),  .SLT_SIGNED(1'b0)) dut_w (.clk(clk), .reset(reset), .bus(bus_w));

    assign bus_u.in_valid  = in_valid && (sel == 0);
    assign bus_s.in_valid  = in_valid && (sel == 1);
    assign bus_w.in_valid  = in_valid && (sel == 2);
    assign bus_u.left      = left;
    assign bus_s.left      = left;
    assign bus_w.left      = left[7:0];
    assign bus_u.right     = right;
    assign bus_s.right     = right;
    assign bus_w.right     = right[7:0];
    assign bus_u.control   = control;
    assign bus_s.control   = control;
    assign bus_w.control   = control;
    assign bus_u.out_ready = out_ready;
    assign bus_s.out_ready = out_ready;
    assign bus_w.out_ready = out_ready;

    logic        mon_in_ready, mon_out_valid, mon_zero, mon_dbz;
    logic [31:0] mon_out;

    always_comb begin
        mon_in_ready  = bus_u.in_ready;
        mon_out_valid = bus_u.out_valid;
        mon_out       = bus_u.out;
        mon_zero      = bus_u.zero;
        mon_dbz       = bus_u.div_by_zero;
        if (sel == 1) begin
            mon_in_ready  = bus_s.in_ready;
            mon_out_valid = bus_s.out_valid;
            mon_out       = bus_s.out;
            mon_zero      = bus_s.zero;
            mon_dbz       = bus_s.div_by_zero;
        end else if (sel == 2) begin
            mon_in_ready  = bus_w.in_ready;
            mon_out_valid = bus_w.out_valid;
            mon_out       = {24'b0, bus_w.out};
            mon_zero      = bus_w.zero;
            mon_dbz       = bus_w.div_by_zero;
        end
    end

    int   n_checks = 0;
    int   n_pass = 0;
    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic vec_t mk(input int d, input logic [3:0] c, input logic [31:0] l,
                                input logic [31:0] r, input logic [31:0] o,
                                input logic dbz, input int e);
        vec_t v;
        v.dut = d; v.ctl = c; v.l = l; v.r = r; v.exp_out = o;
        v.exp_zero = (o == 32'd0); v.exp_dbz = dbz; v.exp_edges = e;
        return v;
    endfunction

    // Issue one op, push its expectation, wait for the result, pop and compare.
    task automatic run_op(input vec_t v, input string tag);
        int   k;
        logic busy_ok;
        vec_t e;
        sel = v.dut;
        k = 0;
        @(negedge clk);
        while (!mon_in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " in_ready"}, 32'(mon_in_ready), 32'd1);
        left = v.l; right = v.r; control = v.ctl; in_valid = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        busy_ok = 1'b1;
        while (!mon_out_valid && k < 200) begin
            if (mon_in_ready) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, 32'(k), 32'(e.exp_edges));
        chk({tag, " busy"}, 32'(busy_ok), 32'd1);
        chk({tag, " out"}, mon_out, e.exp_out);
        chk({tag, " zero"}, 32'(mon_zero), 32'(e.exp_zero));
        chk({tag, " dbz"}, 32'(mon_dbz), 32'(e.exp_dbz));
        $display("op dut=%0d ctl=%b l=%h r=%h -> out=%h zero=%b dbz=%b edges=%0d",
                 v.dut, v.ctl, v.l, v.r, mon_out, mon_zero, mon_dbz, k);
        if (out_ready) begin
            @(negedge clk);
            chk({tag, " handoff"}, {30'b0, mon_out_valid, mon_in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic        stable_ok;

        // Fixed vectors for the 32-bit unsigned instance.
        vecs.push_back(mk(0, C_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 0));
        vecs.push_back(mk(0, C_OR,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 0));
        vecs.push_back(mk(0, C_NOR, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 0));
        vecs.push_back(mk(0, C_SUB, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 0));
        vecs.push_back(mk(0, C_ADD, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b0, 0));
        vecs.push_back(mk(0, C_SLT, 32'h80000000, 32'd1,        32'h0,        1'b0, 0));
        vecs.push_back(mk(0, C_SLT, 32'd1,        32'd2,        32'd1,        1'b0, 0));
        vecs.push_back(mk(0, 4'b0101, 32'd5,      32'd6,        32'h0,        1'b0, 0));
        vecs.push_back(mk(0, C_MUL, 32'h00010003, 32'h00010005, 32'h0008000F, 1'b0, 32));
        vecs.push_back(mk(0, C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32));
        vecs.push_back(mk(0, C_DIVU, 32'd100,     32'd7,        32'd14,       1'b0, 32));
        vecs.push_back(mk(0, C_REMU, 32'd100,     32'd7,        32'd2,        1'b0, 32));
        vecs.push_back(mk(0, C_DIVU, 32'd9,       32'd0,        32'hFFFFFFFF, 1'b1, 32));
        vecs.push_back(mk(0, C_REMU, 32'd9,       32'd0,        32'd9,        1'b1, 32));
        vecs.push_back(mk(0, C_DIVU, 32'd0,       32'd5,        32'd0,        1'b0, 32));
        vecs.push_back(mk(0, C_DIVU, 32'hFFFFFFFF, 32'd10,      32'h19999999, 1'b0, 32));
        vecs.push_back(mk(0, C_REMU, 32'hFFFFFFFF, 32'd10,      32'd5,        1'b0, 32));
        // Random iterative ops, expected values from plain arithmetic.
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom_range(1, 32'h0000FFFF);
            vecs.push_back(mk(0, C_MUL,  a, b, a * b, 1'b0, 32));
            vecs.push_back(mk(0, C_DIVU, a, b, a / b, 1'b0, 32));
            vecs.push_back(mk(0, C_REMU, a, b, a % b, 1'b0, 32));
        end
        // Signed-compare instance.
        vecs.push_back(mk(1, C_SLT, 32'h80000000, 32'd1,        32'd1,        1'b0, 0));
        vecs.push_back(mk(1, C_SLT, 32'd1,        32'h80000000, 32'd0,        1'b0, 0));
        vecs.push_back(mk(1, C_SLT, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 0));
        // 8-bit instance.
        vecs.push_back(mk(2, C_DIVU, 32'd200,     32'd3,        32'd66,       1'b0, 8));
        vecs.push_back(mk(2, C_REMU, 32'd200,     32'd3,        32'd2,        1'b0, 8));
        vecs.push_back(mk(2, C_MUL,  32'd13,      32'd21,       32'd17,       1'b0, 8));
        vecs.push_back(mk(2, C_DIVU, 32'd5,       32'd0,        32'hFF,       1'b1, 8));
        vecs.push_back(mk(2, C_ADD,  32'd250,     32'd6,        32'd0,        1'b0, 0));

        // Reset state.
        sel = 0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'(mon_in_ready), 32'd1);
        chk("reset out_valid", 32'(mon_out_valid), 32'd0);
        chk("reset out", mon_out, 32'd0);
        chk("reset zero", 32'(mon_zero), 32'd1);
        chk("reset dbz", 32'(mon_dbz), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a multiply: abandoned, no output.
        sel = 0;
        @(negedge clk);
        left = 32'h00010003; right = 32'h00010005; control = C_MUL; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun busy", 32'(mon_in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("midrun out_valid", 32'(mon_out_valid), 32'd0);
        chk("midrun in_ready", 32'(mon_in_ready), 32'd1);
        $display("op reset mid-run -> out_valid=%b in_ready=%b", mon_out_valid, mon_in_ready);
        @(negedge clk);
        reset = 1'b0;
        run_op(mk(0, C_ADD, 32'd7, 32'd5, 32'd12, 1'b0, 0), "after_reset");

        // Backpressure with input churn: result and status must not move.
        out_ready = 1'b0;
        run_op(mk(0, C_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 32), "bp");
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            left = $urandom; right = $urandom; control = 4'($urandom); in_valid = 1'b1;
            @(negedge clk);
            if (mon_out !== 32'd14 || mon_out_valid !== 1'b1 || mon_in_ready !== 1'b0 ||
                mon_zero !== 1'b0 || mon_dbz !== 1'b0) stable_ok = 1'b0;
        end
        chk("bp stable", 32'(stable_ok), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp handoff", {30'b0, mon_out_valid, mon_in_ready}, 32'd1);
        chk("bp out kept", mon_out, 32'd14);
        @(negedge clk);
        chk("bp idle", {30'b0, mon_out_valid, mon_in_ready}, 32'd1);
        $display("op backpressure release -> out=%h out_valid=%b", mon_out, mon_out_valid);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
